// File: rtl/video_pattern_scheduler.sv
// Test-pattern video timing generator with a host command port that swaps
// patterns (manual hold or auto-cycle) only on frame boundaries.
module video_pattern_scheduler #(
    parameter int unsigned FRAMES_PER_PATTERN = 60,
    parameter int unsigned H_ACTIVE           = 640,
    parameter int unsigned H_SYNC_START       = 656,
    parameter int unsigned H_SYNC_END         = 752,
    parameter int unsigned H_TOTAL            = 800,
    parameter int unsigned V_ACTIVE           = 480,
    parameter int unsigned V_SYNC_START       = 490,
    parameter int unsigned V_SYNC_END         = 492,
    parameter int unsigned V_TOTAL            = 525
) (
    input  logic       inclk,
    input  logic       inreset,
    input  logic       icmd_valid,
    output logic       icmd_ready,
    input  logic       icmd_auto,
    input  logic [1:0] icmd_pattern,
    output logic [1:0] opattern,
    output logic       oframe_start,
    output logic [7:0] ored,
    output logic [7:0] ogreen,
    output logic [7:0] oblue,
    output logic       ohSync,
    output logic       ovSync,
    output logic       oDE
);

    localparam int unsigned CW = 10;
    localparam int unsigned FW = 8;

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [FW-1:0] r_fcnt;
    logic [1:0]    r_pattern;
    logic          r_auto;
    logic          r_pend;
    logic          r_pend_auto;
    logic [1:0]    r_pend_pat;
    logic          r_ready;

    logic [1:0]    r_pattern_out;
    logic          r_frame_start;
    logic [7:0]    r_red;
    logic [7:0]    r_green;
    logic [7:0]    r_blue;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;

    logic          w_x_last;
    logic          w_boundary;
    logic          w_accept;
    logic          w_de;
    logic          w_hs;
    logic          w_vs;
    logic [7:0]    w_r;
    logic [7:0]    w_g;
    logic [7:0]    w_b;

    assign w_x_last   = (r_x == CW'(H_TOTAL - 1));
    assign w_boundary = w_x_last && (r_y == CW'(V_TOTAL - 1));
    assign w_accept   = icmd_valid && r_ready;

    // Pixel colour and strobes for the current counter position
    always_comb begin
        w_de = (r_x < CW'(H_ACTIVE)) && (r_y < CW'(V_ACTIVE));
        w_hs = (r_x >= CW'(H_SYNC_START)) && (r_x < CW'(H_SYNC_END));
        w_vs = (r_y >= CW'(V_SYNC_START)) && (r_y < CW'(V_SYNC_END));
        w_r  = '0;
        w_g  = '0;
        w_b  = '0;
        if (w_de) begin
            case (r_pattern)
                2'd0: begin
                    if (r_x < CW'(H_ACTIVE / 4)) begin
                        w_r = 8'hff;
                    end else if (r_x < CW'(H_ACTIVE / 2)) begin
                        w_g = 8'hff;
                    end else if (r_x < CW'((3 * H_ACTIVE) / 4)) begin
                        w_b = 8'hff;
                    end else begin
                        w_r = 8'hff;
                        w_g = 8'hff;
                        w_b = 8'hff;
                    end
                end
                2'd1: begin
                    if (r_x[7:0] == r_y[7:0]) begin
                        w_r = 8'hff;
                        w_g = 8'hff;
                        w_b = 8'hff;
                    end
                end
                2'd2: begin
                    if (r_x[5] ^ r_y[5]) begin
                        w_r = 8'hff;
                        w_g = 8'hff;
                        w_b = 8'hff;
                    end
                end
                default: begin
                    w_r = r_x[9:2];
                    w_g = r_x[9:2];
                    w_b = r_x[9:2];
                end
            endcase
        end
    end

    // Counters, command scheduling and the registered output stage
    always_ff @(posedge inclk) begin
        if (inreset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_fcnt        <= '0;
            r_pattern     <= '0;
            r_auto        <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_auto   <= 1'b0;
            r_pend_pat    <= '0;
            r_ready       <= 1'b0;
            r_pattern_out <= '0;
            r_frame_start <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_hs          <= 1'b0;
            r_vs          <= 1'b0;
            r_de          <= 1'b0;
        end else begin
            r_x <= w_x_last ? '0 : r_x + CW'(1);
            if (w_x_last) begin
                r_y <= (r_y == CW'(V_TOTAL - 1)) ? '0 : r_y + CW'(1);
            end

            // A pending command always beats an auto advance on the same boundary
            if (w_boundary) begin
                if (r_pend) begin
                    r_pattern <= r_pend_pat;
                    r_auto    <= r_pend_auto;
                    r_fcnt    <= '0;
                end else if (r_auto) begin
                    if (r_fcnt == FW'(FRAMES_PER_PATTERN - 1)) begin
                        r_pattern <= r_pattern + 2'd1;
                        r_fcnt    <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + FW'(1);
                    end
                end else begin
                    r_fcnt <= '0;
                end
            end

            // A command taken on the boundary cycle stays pending for a full frame
            if (w_accept) begin
                r_pend      <= 1'b1;
                r_pend_auto <= icmd_auto;
                r_pend_pat  <= icmd_pattern;
            end else if (w_boundary) begin
                r_pend <= 1'b0;
            end
            r_ready <= !(w_accept || (r_pend && !w_boundary));

            r_pattern_out <= r_pattern;
            r_frame_start <= (r_x == '0) && (r_y == '0);
            r_red         <= w_r;
            r_green       <= w_g;
            r_blue        <= w_b;
            r_hs          <= w_hs;
            r_vs          <= w_vs;
            r_de          <= w_de;
        end
    end

    assign icmd_ready   = r_ready;
    assign opattern     = r_pattern_out;
    assign oframe_start = r_frame_start;
    assign ored         = r_red;
    assign ogreen       = r_green;
    assign oblue        = r_blue;
    assign ohSync       = r_hs;
    assign ovSync       = r_vs;
    assign oDE          = r_de;

endmodule

// File: tb/tb_video_pattern_scheduler.sv
// Bench for video_pattern_scheduler on a shrunk raster (80x42 total, 64x36 active)
// so a dozen frames fit in a short run; per-frame command table plus reset sequence.
module tb_video_pattern_scheduler;

    localparam int HT = 80;
    localparam int VT = 42;
    localparam int NF = 13;
    localparam int WAIT_MAX = 40000;

    logic       inclk = 1'b0;
    logic       inreset;
    logic       icmd_valid;
    logic       icmd_ready;
    logic       icmd_auto;
    logic [1:0] icmd_pattern;
    logic [1:0] opattern;
    logic       oframe_start;
    logic [7:0] ored;
    logic [7:0] ogreen;
    logic [7:0] oblue;
    logic       ohSync;
    logic       ovSync;
    logic       oDE;

    always #5 inclk = ~inclk;

    video_pattern_scheduler #(
        .FRAMES_PER_PATTERN(2),
        .H_ACTIVE(64), .H_SYNC_START(68), .H_SYNC_END(76), .H_TOTAL(80),
        .V_ACTIVE(36), .V_SYNC_START(38), .V_SYNC_END(40), .V_TOTAL(42)
    ) dut (
        .inclk(inclk), .inreset(inreset),
        .icmd_valid(icmd_valid), .icmd_ready(icmd_ready),
        .icmd_auto(icmd_auto), .icmd_pattern(icmd_pattern),
        .opattern(opattern), .oframe_start(oframe_start),
        .ored(ored), .ogreen(ogreen), .oblue(oblue),
        .ohSync(ohSync), .ovSync(ovSync), .oDE(oDE)
    );

    typedef struct {
        bit         cmd;
        bit         cmd_auto;
        logic [1:0] cmd_pat;
        int         cx;
        int         cy;
        logic [1:0] exp_pat;
    } vec_t;

    vec_t       tab[NF];
    logic [1:0] exp_tab[16];

    int total = 0;
    int bad   = 0;

    logic [29:0] got;
    assign got = {ored, ogreen, oblue, ohSync, ovSync, oDE, oframe_start, opattern};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference pixel: {r,g,b,hs,vs,de,fs,pattern} for raster position (x,y)
    function automatic logic [29:0] exp_pix(input int x, input int y, input logic [1:0] pat);
        logic [9:0] xv;
        logic [9:0] yv;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        xv = 10'(x);
        yv = 10'(y);
        de = (x < 64) && (y < 36);
        hs = (x >= 68) && (x < 76);
        vs = (y >= 38) && (y < 40);
        fs = (x == 0) && (y == 0);
        r = 8'h00; g = 8'h00; b = 8'h00;
        if (de) begin
            case (pat)
                2'd0: begin
                    if (x < 16)      r = 8'hff;
                    else if (x < 32) g = 8'hff;
                    else if (x < 48) b = 8'hff;
                    else begin r = 8'hff; g = 8'hff; b = 8'hff; end
                end
                2'd1: if (xv[7:0] == yv[7:0]) begin r = 8'hff; g = 8'hff; b = 8'hff; end
                2'd2: if (xv[5] ^ yv[5])      begin r = 8'hff; g = 8'hff; b = 8'hff; end
                default: begin r = xv[9:2]; g = xv[9:2]; b = xv[9:2]; end
            endcase
        end
        return {r, g, b, hs, vs, de, fs, pat};
    endfunction

    // Raster position model: (cx,cy,cf) = counter now, (px,py,pf) = what the outputs show
    int cx, cy, cf, px, py, pf;
    bit pvalid = 1'b0;
    always @(posedge inclk) begin
        if (inreset) begin
            cx <= 0; cy <= 0; cf <= 0; pvalid <= 1'b0;
        end else begin
            px <= cx; py <= cy; pf <= cf; pvalid <= 1'b1;
            if (cx == HT - 1) begin
                cx <= 0;
                if (cy == VT - 1) begin
                    cy <= 0;
                    cf <= cf + 1;
                end else begin
                    cy <= cy + 1;
                end
            end else begin
                cx <= cx + 1;
            end
        end
    end

    bit          mon_en = 1'b0;
    int          ferr, fx, fy, de_cnt, hs_cnt, vs_cnt, fs_cnt;
    logic [29:0] fgot, fexp, mexp;

    always @(negedge inclk) begin
        if (mon_en) begin
            if (!pvalid) begin
                check("reset_outputs", 32'(got), 32'd0);
            end else if (pf < 16) begin
                if (px == 0 && py == 0) begin
                    ferr = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
                end
                mexp = exp_pix(px, py, exp_tab[pf]);
                if (got !== mexp) begin
                    if (ferr == 0) begin fx = px; fy = py; fgot = got; fexp = mexp; end
                    ferr++;
                end
                de_cnt += int'(oDE);
                hs_cnt += int'(ohSync);
                vs_cnt += int'(ovSync);
                fs_cnt += int'(oframe_start);
                if (px == HT - 1 && py == VT - 1 && pf < NF) begin
                    total++;
                    if (ferr != 0) begin
                        bad++;
                        $display("FAIL frame%0d_pixels: %0d bad, first x=%0d y=%0d got %h want %h",
                                 pf, ferr, fx, fy, fgot, fexp);
                    end
                    check($sformatf("frame%0d_de_count", pf), 32'(de_cnt), 32'd2304);
                    check($sformatf("frame%0d_hs_count", pf), 32'(hs_cnt), 32'd336);
                    check($sformatf("frame%0d_vs_count", pf), 32'(vs_cnt), 32'd160);
                    check($sformatf("frame%0d_fs_count", pf), 32'(fs_cnt), 32'd1);
                end
            end
        end
    end

    task automatic wait_at(input int f, input int x, input int y);
        int n;
        n = 0;
        while (!(cf == f && cx == x && cy == y) && n < WAIT_MAX) begin
            @(negedge inclk);
            n++;
        end
        if (n >= WAIT_MAX) begin
            total++;
            bad++;
            $display("FAIL wait_f%0d_x%0d_y%0d: timed out after %0d cycles, want position reached", f, x, y, n);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "position never reached");
        end
    endtask

    task automatic issue(input int f, input int x, input int y, input bit a, input logic [1:0] p);
        int af;
        wait_at(f, x, y);
        check($sformatf("f%0d_ready_before_cmd", f), 32'(icmd_ready), 32'd1);
        icmd_valid = 1'b1; icmd_auto = a; icmd_pattern = p;
        @(negedge inclk);
        icmd_valid = 1'b0;
        check($sformatf("f%0d_ready_drop", f), 32'(icmd_ready), 32'd0);
        af = (x == HT - 1 && y == VT - 1) ? f + 1 : f;
        wait_at(af, HT - 1, VT - 1);
        check($sformatf("f%0d_ready_low_at_boundary", af), 32'(icmd_ready), 32'd0);
        @(negedge inclk);
        check($sformatf("f%0d_ready_return", af), 32'(icmd_ready), 32'd1);
    endtask

    initial begin
        // cmd, auto, pat, at (x,y), pattern shown during that frame
        tab[0]  = '{0, 0, 2'd0,  0,  0, 2'd0};
        tab[1]  = '{1, 0, 2'd2, 30, 20, 2'd0};
        tab[2]  = '{1, 0, 2'd1, 79, 41, 2'd2};
        tab[3]  = '{0, 0, 2'd0,  0,  0, 2'd2};
        tab[4]  = '{1, 1, 2'd3, 10,  5, 2'd1};
        tab[5]  = '{0, 0, 2'd0,  0,  0, 2'd3};
        tab[6]  = '{0, 0, 2'd0,  0,  0, 2'd3};
        tab[7]  = '{0, 0, 2'd0,  0,  0, 2'd0};
        tab[8]  = '{0, 0, 2'd0,  0,  0, 2'd0};
        tab[9]  = '{0, 0, 2'd0,  0,  0, 2'd1};
        tab[10] = '{1, 0, 2'd1, 40, 30, 2'd1};
        tab[11] = '{0, 0, 2'd0,  0,  0, 2'd1};
        tab[12] = '{0, 0, 2'd0,  0,  0, 2'd1};
        for (int i = 0; i < 16; i++) exp_tab[i] = (i < NF) ? tab[i].exp_pat : 2'd1;

        inreset = 1'b1; icmd_valid = 1'b0; icmd_auto = 1'b0; icmd_pattern = 2'd0;
        @(negedge inclk);
        mon_en = 1'b1;
        repeat (2) @(negedge inclk);
        check("reset_ready", 32'(icmd_ready), 32'd0);
        check("reset_video", 32'(got), 32'd0);
        inreset = 1'b0;
        @(negedge inclk);
        check("ready_after_reset", 32'(icmd_ready), 32'd1);
        check("first_pixel", 32'(got), 32'(exp_pix(0, 0, 2'd0)));

        for (int i = 0; i < NF; i++) begin
            if (tab[i].cmd) issue(i, tab[i].cx, tab[i].cy, tab[i].cmd_auto, tab[i].cmd_pat);
        end

        // Reset mid-frame with a command pending: pattern 3 must never appear
        wait_at(13, 5, 2);
        icmd_valid = 1'b1; icmd_auto = 1'b0; icmd_pattern = 2'd3;
        @(negedge inclk);
        icmd_valid = 1'b0;
        check("rst_pending_ready", 32'(icmd_ready), 32'd0);
        wait_at(13, 30, 20);
        inreset = 1'b1;
        @(negedge inclk);
        check("rst_mid_video", 32'(got), 32'd0);
        check("rst_mid_ready", 32'(icmd_ready), 32'd0);
        inreset = 1'b0;
        @(negedge inclk);
        check("rst_mid_ready_back", 32'(icmd_ready), 32'd1);
        check("rst_mid_first_pixel", 32'(got), 32'(exp_pix(0, 0, 2'd0)));
        wait_at(2, 0, 0);
        @(negedge inclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
